window_generator: RTL and testbench

Streaming neighbourhood-window builder that sits directly upstream of the filter operation stage. It accepts one 9-bit {valid, pixel} word per clock in raster order. It keeps Ope_Size-1 line buffers plus an Ope_Size x Ope_Size register window, and drives the packed window bus that the operation stage consumes. Positions that fall outside the image, above the first line or left of the first column, are flagged invalid and zeroed.

---
 rtl/window_generator.sv | 115 +++++++++++
 tb/tb_window_generator.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/window_generator.sv
// rtl/window_generator.sv - streaming Ope_Size x Ope_Size neighbourhood window builder
//
// Builds a square pixel window from a raster-order pixel stream. It keeps
// Ope_Size-1 line buffers and an Ope_Size x Ope_Size register window. Window
// positions above the first line or left of the first column are marked
// invalid, and their pixel bits are zeroed.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   reflesh  - synchronous active-high frame restart (same effect as rst)
//   in       - {valid, pixel[7:0]} input word, one per clock
//   data_bus - packed window, element d[y][x] at [((y*Ope_Size)+x)*9 +: 9],
//              bit 8 = element valid, bits 7:0 = pixel
module window_generator #(
    parameter int Ope_Size  = 3,
    parameter int Img_Width = 640
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             reflesh,
    input  logic [8:0]                       in,
    output logic [9*Ope_Size*Ope_Size-1:0]   data_bus
);

    localparam int N      = Ope_Size;
    localparam int COL_W  = $clog2(Img_Width);
    localparam int LINE_W = $clog2(Ope_Size);
    localparam int BUS_W  = 9 * N * N;

    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [7:0]        win_q [N][N];
    logic [7:0]        win_d [N][N];
    logic [BUS_W-1:0]  out_q, out_d;
    logic              elem_v;
    logic              clear;

    // lb_q[k] is line buffer k+1: it holds the line (k+1) lines earlier.
    logic [7:0]        lb_q [N-1][Img_Width];

    assign clear    = rst | reflesh;
    assign data_bus = out_q;

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        win_d  = win_q;
        out_d  = out_q;
        elem_v = 1'b0;
        if (in[8]) begin
            if (col_q == COL_W'(Img_Width - 1)) begin
                col_d = '0;
                if (line_q != LINE_W'(N - 1)) begin
                    line_d = line_q + LINE_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end

            for (int y = 0; y < N; y++) begin
                for (int x = 0; x < N - 1; x++) begin
                    win_d[y][x] = win_q[y][x+1];
                end
            end
            win_d[N-1][N-1] = in[7:0];
            for (int y = 0; y < N - 1; y++) begin
                win_d[y][N-1] = lb_q[N-2-y][col_q];
            end

            // Validity uses the counters as they were before this pixel.
            for (int y = 0; y < N; y++) begin
                for (int x = 0; x < N; x++) begin
                    elem_v = (int'(line_q) >= N - 1 - y) && (int'(col_q) >= N - 1 - x);
                    out_d[((y*N)+x)*9 +: 9] = elem_v ? {1'b1, win_d[y][x]} : 9'h000;
                end
            end
        end else begin
            // Idle cycle: drop every valid flag but keep the pixel bits.
            for (int i = 0; i < N * N; i++) begin
                out_d[i*9+8] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            col_q  <= '0;
            line_q <= '0;
            out_q  <= '0;
            for (int y = 0; y < N; y++) begin
                for (int x = 0; x < N; x++) begin
                    win_q[y][x] <= 8'h00;
                end
            end
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
            out_q  <= out_d;
            win_q  <= win_d;
        end
    end

    // Line buffers are a per-column delay chain. They are not cleared on
    // reset because the valid masking hides stale contents.
    always_ff @(posedge clk) begin
        if (!clear && in[8]) begin
            lb_q[0][col_q] <= in[7:0];
            for (int k = 1; k < N - 1; k++) begin
                lb_q[k][col_q] <= lb_q[k-1][col_q];
            end
        end
    end

endmodule

// File: tb/tb_window_generator.sv
// tb/tb_window_generator.sv - directed vector bench for window_generator
module tb_window_generator;

    localparam int OS = 3;
    localparam int IW = 4;
    localparam int BW = 9 * OS * OS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          reflesh = 1'b0;
    logic [8:0]    in = 9'h000;
    logic [BW-1:0] data_bus;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [8:0]    in;
        logic [BW-1:0] exp;
    } vec_t;

    vec_t vec [12];

    window_generator #(.Ope_Size(OS), .Img_Width(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .reflesh  (reflesh),
        .in       (in),
        .data_bus (data_bus)
    );

    always #5 clk = ~clk;

    // Arguments are d[y][x] in the order d00 d01 d02 d10 d11 d12 d20 d21 d22;
    // a value of 0 means the element is invalid.
    function automatic logic [BW-1:0] win(input int a00, input int a01, input int a02,
                                          input int a10, input int a11, input int a12,
                                          input int a20, input int a21, input int a22);
        int            v [9];
        logic [BW-1:0] r;
        v = '{a00, a01, a02, a10, a11, a12, a20, a21, a22};
        r = '0;
        for (int i = 0; i < 9; i++) begin
            r[i*9 +: 9] = (v[i] == 0) ? 9'h000 : {1'b1, 8'(v[i])};
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] clr_valid(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < 9; i++) r[i*9+8] = 1'b0;
        return r;
    endfunction

    task automatic step(input logic [8:0] i, input logic r, input logic f);
        in      = i;
        rst     = r;
        reflesh = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [BW-1:0] exp);
        n_vec++;
        if (data_bus !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, data_bus, exp);
        end
    endtask

    task automatic do_reset();
        step(9'h1FF, 1'b1, 1'b0);
        step(9'h000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [BW-1:0] held;

        vec[0]  = '{{1'b1, 8'd1},  win(0,0,0, 0,0,0, 0,0,1)};
        vec[1]  = '{{1'b1, 8'd2},  win(0,0,0, 0,0,0, 0,1,2)};
        vec[2]  = '{{1'b1, 8'd3},  win(0,0,0, 0,0,0, 1,2,3)};
        vec[3]  = '{{1'b1, 8'd4},  win(0,0,0, 0,0,0, 2,3,4)};
        vec[4]  = '{{1'b1, 8'd5},  win(0,0,0, 0,0,1, 0,0,5)};
        vec[5]  = '{{1'b1, 8'd6},  win(0,0,0, 0,1,2, 0,5,6)};
        vec[6]  = '{{1'b1, 8'd7},  win(0,0,0, 1,2,3, 5,6,7)};
        vec[7]  = '{{1'b1, 8'd8},  win(0,0,0, 2,3,4, 6,7,8)};
        vec[8]  = '{{1'b1, 8'd9},  win(0,0,1, 0,0,5, 0,0,9)};
        vec[9]  = '{{1'b1, 8'd10}, win(0,1,2, 0,5,6, 0,9,10)};
        vec[10] = '{{1'b1, 8'd11}, win(1,2,3, 5,6,7, 9,10,11)};
        vec[11] = '{{1'b1, 8'd12}, win(2,3,4, 6,7,8, 10,11,12)};

        // Reset held two cycles with an active pixel on the input.
        step(9'h1FF, 1'b1, 1'b0);
        chk("reset_c0", '0);
        step(9'h1FF, 1'b1, 1'b0);
        chk("reset_c1", '0);
        step(9'h000, 1'b0, 1'b0);
        chk("reset_after", '0);

        // Contiguous frame.
        for (int i = 0; i < 12; i++) begin
            step(vec[i].in, 1'b0, 1'b0);
            chk($sformatf("contig_p%0d", i + 1), vec[i].exp);
        end

        // Same frame with 1..3 idle cycles before every pixel.
        do_reset();
        held = '0;
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k <= i % 3; k++) begin
                step({1'b0, 8'hAB}, 1'b0, 1'b0);
                chk($sformatf("gap_idle_p%0d", i + 1), held);
            end
            step(vec[i].in, 1'b0, 1'b0);
            chk($sformatf("gap_p%0d", i + 1), vec[i].exp);
            held = clr_valid(vec[i].exp);
        end

        // reflesh mid-frame discards the simultaneous pixel.
        do_reset();
        for (int i = 0; i < 6; i++) step(vec[i].in, 1'b0, 1'b0);
        chk("pre_reflesh_p6", vec[5].exp);
        step({1'b1, 8'd99}, 1'b0, 1'b1);
        chk("reflesh", '0);
        step({1'b1, 8'd20}, 1'b0, 1'b0);
        chk("post_reflesh_20", win(0,0,0, 0,0,0, 0,0,20));
        step({1'b1, 8'd21}, 1'b0, 1'b0);
        chk("post_reflesh_21", win(0,0,0, 0,0,0, 0,20,21));

        // Six full lines: line counter saturates, buffers keep tracking.
        do_reset();
        for (int l = 0; l < 6; l++) begin
            for (int c = 0; c < IW; c++) begin
                step({1'b1, 8'(l * IW + c + 1)}, 1'b0, 1'b0);
                if (l == 5 && c == 0) chk("sat_l5_c0", win(0,0,13, 0,0,17, 0,0,21));
                if (l == 5 && c == 3) chk("sat_l5_c3", win(14,15,16, 18,19,20, 22,23,24));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
